// File: rtl/perspective_divide_if.sv
// ---------------------------------------------------------------------------
// perspective_divide_if
// Vertex stream bundle between the transform stage and the perspective
// divider.
//   pos_in[3:0]  clip-space vertex {x, y, z, w}, signed Q16.16
//   v_in         single-cycle valid for pos_in
//   in_ready     divider can take a vertex this cycle
//   ndc[2:0]     {x/w, y/w, z/w}, signed Q16.16, saturated
//   cull         result belongs to a vertex with w <= 0 (ndc is zero)
//   v_out        one-cycle result strobe
//   overrun      sticky: a v_in pulse was dropped
// Modports: slave = the divider, master = the producer/consumer side.
// ---------------------------------------------------------------------------
interface perspective_divide_if;
  logic [3:0][31:0] pos_in;
  logic             v_in;
  logic             in_ready;
  logic [2:0][31:0] ndc;
  logic             cull;
  logic             v_out;
  logic             overrun;

  modport slave (
    input  pos_in, v_in,
    output in_ready, ndc, cull, v_out, overrun
  );

  modport master (
    output pos_in, v_in,
    input  in_ready, ndc, cull, v_out, overrun
  );
endinterface

// File: rtl/perspective_divide.sv
// ---------------------------------------------------------------------------
// perspective_divide
// Turns clip-space vertices into normalized device coordinates x/w, y/w, z/w.
// A 33-iteration restoring divider forms 1/w (2^(2*FRAC) / w), then one shared
// signed multiplier scales x, y and z in three consecutive cycles. Vertices
// with w <= 0 skip the arithmetic and come out flagged as culled.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    perspective_divide_if.slave (pos_in/v_in in, ndc/cull/v_out out,
//          in_ready, overrun)
// Optional feature: define PERSP_DIV_SKID_EN to add a one-entry holding
// register so a vertex arriving while busy is kept and started straight
// from OUT without an IDLE cycle.
// ---------------------------------------------------------------------------
module perspective_divide #(
  parameter int FRAC = 16
) (
  input logic               clk,
  input logic               rst_n,
  perspective_divide_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DIV, MUL, OUT} state_t;

  localparam logic [32:0]        DIVIDEND = 33'd1 << (2 * FRAC);
  localparam logic signed [63:0] SAT_MAX  = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN  = 64'shFFFF_FFFF_8000_0000;

  state_t           state_reg;
  logic [31:0]      x_reg, y_reg, z_reg, w_reg;
  logic             culled_reg;
  logic [31:0]      rem_reg;
  logic [31:0]      quo_reg;
  logic [5:0]       cnt_reg;
  logic [31:0]      recip_reg;
  logic [1:0]       mul_idx_reg;
  logic [2:0][31:0] res_reg;
  logic [2:0][31:0] ndc_reg;
  logic             cull_reg;
  logic             v_out_reg;
  logic             in_ready_reg;
  logic             overrun_reg;

`ifdef PERSP_DIV_SKID_EN
  logic             hold_valid_reg;
  logic [3:0][31:0] hold_pos_reg;
  logic             hold_load;
  logic             hold_valid_next;
`endif

  // Vertex start selection (from the input port, or from the holding register).
  logic             start;
  logic [3:0][31:0] start_pos;
  logic             start_cull;
  logic             next_idle;
  logic             in_ready_next;
  logic             overrun_set;

  always_comb begin
`ifdef PERSP_DIV_SKID_EN
    start     = ((state_reg == IDLE) && bus.v_in) ||
                ((state_reg == OUT) && (hold_valid_reg || bus.v_in));
    start_pos = ((state_reg == OUT) && hold_valid_reg) ? hold_pos_reg : bus.pos_in;
    // In OUT a full register drains and may refill in the same cycle; in
    // DIV/MUL only an empty register takes a vertex. IDLE never holds.
    case (state_reg)
      IDLE: begin
        hold_load       = 1'b0;
        hold_valid_next = 1'b0;
      end
      OUT: begin
        hold_load       = hold_valid_reg && bus.v_in;
        hold_valid_next = hold_load;
      end
      default: begin
        hold_load       = !hold_valid_reg && bus.v_in;
        hold_valid_next = hold_valid_reg || bus.v_in;
      end
    endcase
    overrun_set = bus.v_in && hold_valid_reg &&
                  ((state_reg == DIV) || (state_reg == MUL));
`else
    start       = (state_reg == IDLE) && bus.v_in;
    start_pos   = bus.pos_in;
    overrun_set = bus.v_in && (state_reg != IDLE);
`endif
    start_cull = start_pos[0][31] || (start_pos[0] == 32'd0);
    next_idle  = ((state_reg == IDLE) || (state_reg == OUT)) && !start;
`ifdef PERSP_DIV_SKID_EN
    in_ready_next = next_idle || !hold_valid_next;
`else
    in_ready_next = next_idle;
`endif
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract w when it fits.
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;
  logic [32:0] quo_final;

  always_comb begin
    trial     = {rem_reg, DIVIDEND[cnt_reg]};
    diff      = trial - {1'b0, w_reg};
    fits      = trial >= {1'b0, w_reg};
    quo_final = {quo_reg, fits};
  end

  // Shared multiplier: operand order x, y, z; reciprocal is always positive.
  logic [31:0]        mul_op;
  logic signed [63:0] a_ext, b_ext, prod, shifted;
  logic [31:0]        prod_sat;

  always_comb begin
    case (mul_idx_reg)
      2'd0:    mul_op = x_reg;
      2'd1:    mul_op = y_reg;
      default: mul_op = z_reg;
    endcase
    a_ext   = {{32{mul_op[31]}}, mul_op};
    b_ext   = {32'd0, recip_reg};
    prod    = a_ext * b_ext;
    shifted = prod >>> FRAC;
    if (shifted > SAT_MAX)
      prod_sat = 32'h7FFF_FFFF;
    else if (shifted < SAT_MIN)
      prod_sat = 32'h8000_0000;
    else
      prod_sat = shifted[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      z_reg          <= '0;
      w_reg          <= '0;
      culled_reg     <= 1'b0;
      rem_reg        <= '0;
      quo_reg        <= '0;
      cnt_reg        <= '0;
      recip_reg      <= '0;
      mul_idx_reg    <= '0;
      res_reg        <= '0;
      ndc_reg        <= '0;
      cull_reg       <= 1'b0;
      v_out_reg      <= 1'b0;
      in_ready_reg   <= 1'b1;
      overrun_reg    <= 1'b0;
`ifdef PERSP_DIV_SKID_EN
      hold_valid_reg <= 1'b0;
      hold_pos_reg   <= '0;
`endif
    end else begin
      v_out_reg    <= 1'b0;
      in_ready_reg <= in_ready_next;
      if (overrun_set)
        overrun_reg <= 1'b1;
`ifdef PERSP_DIV_SKID_EN
      hold_valid_reg <= hold_valid_next;
      if (hold_load)
        hold_pos_reg <= bus.pos_in;
`endif

      case (state_reg)
        IDLE: ;
        DIV: begin
          rem_reg <= fits ? diff[31:0] : trial[31:0];
          quo_reg <= quo_final[31:0];
          cnt_reg <= cnt_reg - 6'd1;
          if (cnt_reg == 6'd0) begin
            // Quotient >= 2^31 only for w = 1 or 2 LSB; clamp to max positive.
            recip_reg   <= (quo_final[32:31] != 2'b00) ? 32'h7FFF_FFFF : quo_final[31:0];
            mul_idx_reg <= 2'd0;
            state_reg   <= MUL;
          end
        end
        MUL: begin
          res_reg[2'd2 - mul_idx_reg] <= prod_sat;
          mul_idx_reg <= mul_idx_reg + 2'd1;
          if (mul_idx_reg == 2'd2)
            state_reg <= OUT;
        end
        OUT: begin
          v_out_reg <= 1'b1;
          cull_reg  <= culled_reg;
          ndc_reg   <= culled_reg ? '0 : res_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Loading a vertex overrides the OUT -> IDLE transition above.
      if (start) begin
        x_reg      <= start_pos[3];
        y_reg      <= start_pos[2];
        z_reg      <= start_pos[1];
        w_reg      <= start_pos[0];
        culled_reg <= start_cull;
        rem_reg    <= '0;
        quo_reg    <= '0;
        cnt_reg    <= 6'd32;
        state_reg  <= start_cull ? OUT : DIV;
      end
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.ndc      = ndc_reg;
  assign bus.cull     = cull_reg;
  assign bus.v_out    = v_out_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_perspective_divide.sv
// ---------------------------------------------------------------------------
// tb_perspective_divide
// Directed, table-driven bench for perspective_divide: reset state, a set of
// vertices with hand-computed NDC results and latencies, back-to-back culled
// vertex, dropped/held second vertex, and reset in the middle of a division.
// ---------------------------------------------------------------------------
module tb_perspective_divide;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  perspective_divide_if bus ();

  perspective_divide #(.FRAC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] x, y, z, w;
    logic [31:0] ex, ey, ez;
    logic        ecull;
    int          elat;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [31:0] x, y, z, w, ex, ey, ez,
                              input logic ecull, input int elat);
    vec_t v;
    v.x = x; v.y = y; v.z = z; v.w = w;
    v.ex = ex; v.ey = ey; v.ez = ez;
    v.ecull = ecull; v.elat = elat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_pos(input vec_t v);
    bus.pos_in[3] = v.x;
    bus.pos_in[2] = v.y;
    bus.pos_in[1] = v.z;
    bus.pos_in[0] = v.w;
  endtask

  // Pulse v_in for one cycle; returns at the falling edge after the accept edge.
  task automatic send(input vec_t v);
    @(negedge clk);
    drive_pos(v);
    bus.v_in = 1'b1;
    @(negedge clk);
    bus.v_in = 1'b0;
  endtask

  // k = number of rising edges after the accept edge until v_out is seen.
  task automatic wait_vout(output int k);
    k = 0;
    while (bus.v_out !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_reset();
    bus.v_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulses at t=0 (vecs[0]) and t=10 (vecs[1]), optional third at t=15.
  task automatic two_pulse(input bit third);
    int nv, t1, t2;
    logic [31:0] second_x;
    nv = 0; t1 = -1; t2 = -1; second_x = '0;
    for (int t = 0; t < 130; t++) begin
      @(negedge clk);
      if (bus.v_out === 1'b1) begin
        nv++;
        if (nv == 1) t1 = t;
        else begin
          t2 = t;
          second_x = bus.ndc[2];
        end
      end
      drive_pos((t == 10) ? vecs[1] : vecs[0]);
      bus.v_in = (t == 0) || (t == 10) || (third && t == 15);
    end
    bus.v_in = 1'b0;
    $display("two_pulse third=%0d: v_out count %0d at t=%0d,%0d overrun=%0b",
             third, nv, t1, t2, bus.overrun);
    check("first_vout_time", 32'(t1), 32'd38);
`ifdef PERSP_DIV_SKID_EN
    check("skid_vout_count", 32'(nv), 32'd2);
    check("skid_gap_37_or_38", 32'((t2 - t1 == 37) || (t2 - t1 == 38)), 32'd1);
    check("skid_second_x", second_x, 32'h0002_0000);
    check("skid_overrun", 32'(bus.overrun), 32'(third));
`else
    check("noskid_vout_count", 32'(nv), 32'd1);
    check("noskid_overrun", 32'(bus.overrun), 32'd1);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    vec_t v;

    bus.v_in = 1'b0;
    bus.pos_in = '0;

    vecs[0] = mk(32'h0003_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0002_0000,
                 32'h0001_8000, 32'hFFFF_8000, 32'h0000_4000, 1'b0, 37);
    vecs[1] = mk(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000,
                 32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 1'b0, 37);
    vecs[2] = mk(32'h1234_5678, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_0000,
                 32'h0, 32'h0, 32'h0, 1'b1, 1);
    vecs[3] = mk(32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0001,
                 32'h7FFF_FFFF, 32'h8000_0001, 32'h0, 1'b0, 37);
    vecs[4] = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000,
                 32'h0, 32'h0, 32'h0, 1'b1, 1);
    vecs[5] = mk(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF,
                 32'h0000_FFFF, 32'hFFFF_0000, 32'h0, 1'b0, 37);
    vecs[6] = mk(32'h7FFF_0000, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0004_0000,
                 32'h1FFF_C000, 32'hFFFF_FFFF, 32'h0000_4000, 1'b0, 37);
    vecs[7] = mk(32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002,
                 32'h0000_FFFF, 32'hFFFF_8000, 32'h0000_7FFF, 1'b0, 37);
    vecs[8] = mk(32'h0001_0000, 32'h0003_0000, 32'hFFFD_0000, 32'h0000_0003,
                 32'h5555_5555, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 37);
    vecs[9] = mk(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h8000_0000,
                 32'h0, 32'h0, 32'h0, 1'b1, 1);

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_v_out", 32'(bus.v_out), 32'd0);
    check("rst_cull", 32'(bus.cull), 32'd0);
    check("rst_ndc_x", bus.ndc[2], 32'd0);
    check("rst_ndc_y", bus.ndc[1], 32'd0);
    check("rst_ndc_z", bus.ndc[0], 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table-driven vertices.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      send(v);
      check($sformatf("v%0d_busy", i), 32'(bus.in_ready), 32'd0);
      wait_vout(k);
      $display("vec %0d: w=%08h lat=%0d ndc=%08h %08h %08h cull=%0b",
               i, v.w, k, bus.ndc[2], bus.ndc[1], bus.ndc[0], bus.cull);
      check($sformatf("v%0d_latency", i), 32'(k), 32'(v.elat));
      check($sformatf("v%0d_cull", i), 32'(bus.cull), 32'(v.ecull));
      check($sformatf("v%0d_ndc_x", i), bus.ndc[2], v.ex);
      check($sformatf("v%0d_ndc_y", i), bus.ndc[1], v.ey);
      check($sformatf("v%0d_ndc_z", i), bus.ndc[0], v.ez);
      @(negedge clk);
      check($sformatf("v%0d_pulse_end", i), 32'(bus.v_out), 32'd0);
      check($sformatf("v%0d_ndc_hold", i), bus.ndc[2], v.ex);
      check($sformatf("v%0d_ready_again", i), 32'(bus.in_ready), 32'd1);
    end
    check("table_overrun", 32'(bus.overrun), 32'd0);

    // Reset at E20 of a division: in-flight vertex is lost.
    send(vecs[0]);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.v_out === 1'b1) seen++;
    end
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.v_out === 1'b1) seen++;
    end
    $display("mid_div_reset: v_out pulses after reset %0d", seen);
    check("mid_rst_no_vout", 32'(seen), 32'd0);
    check("mid_rst_ndc_x", bus.ndc[2], 32'd0);
    check("mid_rst_ndc_y", bus.ndc[1], 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(vecs[0]);
    wait_vout(k);
    $display("post_reset vertex: lat=%0d ndc_x=%08h", k, bus.ndc[2]);
    check("post_rst_latency", 32'(k), 32'd37);
    check("post_rst_ndc_x", bus.ndc[2], 32'h0001_8000);

    // Two pulses 10 cycles apart.
    do_reset();
    two_pulse(1'b0);
`ifdef PERSP_DIV_SKID_EN
    do_reset();
    two_pulse(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
